vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Sits between the 6502 bus, the VGA scanout logic and the single-port 160x120x3-bit framebuffer RAM, and owns that RAM's only port. Scanout reads get absolute priority. CPU pixel writes are posted through an X/Y/pixel register interface into a 4-entry write FIFO, and drain into RAM in cycles scanout leaves free. An optional clear engine fills the whole framebuffer with one colour.

## Interface
Parameters:
- FIFO_DEPTH, 4: posted-write FIFO entries (power of two, ≥2)
- FB_W, 160: framebuffer width in pixels
- FB_H, 120: framebuffer height in pixels

Ports:
- CLK  in  1  system clock (50 MHz); one clock domain
- RST  in  1  synchronous, active-high reset
- CE  in  1  CPU access strobe, one CLK cycle per access
- RW  in  1  1 = CPU read, 0 = CPU write
- ADDR  in  2  register select
- DATA_IN  in  8  CPU write data
- DATA_OUT  out  8  CPU read data, registered
- SCAN_REQ  in  1  scanout read request
- SCAN_ADDR  in  15  scanout pixel address (y*160+x)
- SCAN_DATA  out  3  scanout read data
- SCAN_VALID  out  1  SCAN_DATA valid
- RAM_ADDR  out  15  RAM address
- RAM_WE  out  1  RAM write enable
- RAM_WDATA  out  3  RAM write data
- RAM_RDATA  in  3  RAM read data (synchronous, 1-cycle latency)

## Operation
- Register map:
  - 0 = X (8 bits).
  - 1 = Y (7 bits).
  - 2 = PIXEL. A write enqueues {addr = Y*160+X, colour = DATA_IN[2:0]}, then advances X. When X=159, X goes to 0 and Y increments. At X=159, Y=119, both wrap to 0.
  - 3 = CMD on write:
    - bit0 starts a clear with colour DATA_IN[3:1].
    - bit7 clears ERR.
  - 3 = STATUS on read: {4'b0, ERR, CLR_BUSY, FULL, EMPTY}.
  - Reads of registers 0 and 1 return X and Y (zero-extended). A read of register 2 returns 0.
- Address arithmetic: (Y<<7)+(Y<<5)+X, computed at enqueue time in 15 bits. Each FIFO entry is 18 bits.
- Out-of-range PIXEL write (X≥160 or Y≥120): not enqueued, ERR set, X/Y unchanged.
- PIXEL write with FIFO full: dropped, ERR set, X/Y unchanged.
- RAM slot priority each cycle:
  1. SCAN_REQ.
  2. Clear engine, if CLR_BUSY.
  3. FIFO head, if not EMPTY.
  4. Otherwise idle: RAM_WE=0, RAM_ADDR holds its last value.
- FIFO drain is stalled while CLR_BUSY. Pixel writes posted during a clear therefore land after it and are never overwritten. They still enqueue during the clear; ERR is set if the FIFO fills.
- Clear FSM:
  - IDLE: CMD bit0 loads colour, sets counter=0, moves to FILL.
  - FILL: counter advances only on granted slots. After the slot with counter=19199 is granted, moves to IDLE.
  - CMD bit0 while in FILL is ignored.
- Simultaneous enqueue and dequeue with FIFO full: both occur, and FULL stays asserted.
- Reset values: DATA_OUT=0, SCAN_DATA=0, SCAN_VALID=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, X=Y=0, FIFO empty, ERR=0, FSM in IDLE. Reset mid-clear or with a non-empty FIFO abandons all pending writes.

## Timing
- RAM_ADDR, RAM_WE and RAM_WDATA are combinational from the grant in the same cycle.
- Scanout: SCAN_REQ in cycle n produces SCAN_VALID=1 and SCAN_DATA=RAM_RDATA in cycle n+1. SCAN_VALID is 0 in every other cycle.
- CPU write: the register updates at the CLK edge ending the CE cycle. The enqueued entry is eligible for RAM from the next cycle.
- CPU read: DATA_OUT is valid the cycle after CE and holds until the next read.
- STATUS reflects state as of the CE edge.
- Full clear with no scanout takes 19200 cycles. Each granted scanout cycle adds one cycle.
- A FIFO entry with no contention reaches RAM in the cycle after its enqueue.

## Configuration
- FB_CLEAR_EN defined: the clear FSM and counter are built as described above.
- FB_CLEAR_EN undefined:
  - CMD bit0 has no effect.
  - CLR_BUSY reads 0.
  - The slot priority is SCAN_REQ, then FIFO.
  - CMD bit7 (ERR clear) still works.

## Structure
- Shared package vga_pkg holds FB_W, FB_H, FB_PIXELS=19200, the register indices (REG_X, REG_Y, REG_PIXEL, REG_CMD), the STATUS bit positions, the 15-bit address type and the clear FSM state enum.
- One sub-module, fb_write_fifo: a synchronous FIFO with push, pop, full, empty and data ports.
- Arbitration, register file and clear FSM stay in the top module.

## Test plan
- Reset, then read STATUS → 8'h01, with RAM_WE=0 and SCAN_VALID=0.
- Write X=159, Y=0, PIXEL=3'b101 with no scanout → RAM write at addr 159, data 5. X reads 0 and Y reads 1.
- Hold SCAN_REQ high for 10 cycles while posting 3 pixels → all RAM writes occur after SCAN_REQ drops, in order. SCAN_VALID is high for exactly 10 cycles, each starting one cycle after its request.
- Hold SCAN_REQ high and post 5 pixels with FIFO_DEPTH=4 → fifth write dropped, STATUS=8'h0A (FULL and ERR). After CMD 8'h80, ERR reads 0.
- Write Y=120, then PIXEL → no enqueue, ERR=1, X and Y unchanged.
- With FB_CLEAR_EN: CMD 8'h05 (colour 2), then post one pixel at addr 0 with colour 7 → 19200 writes of 2, then a write of 7 at addr 0. CLR_BUSY reads 1 until the last clear write.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 120;
    localparam int unsigned FB_PIXELS = 19200;

    localparam logic [1:0] REG_X     = 2'd0;
    localparam logic [1:0] REG_Y     = 2'd1;
    localparam logic [1:0] REG_PIXEL = 2'd2;
    localparam logic [1:0] REG_CMD   = 2'd3;

    localparam int unsigned STAT_EMPTY    = 0;
    localparam int unsigned STAT_FULL     = 1;
    localparam int unsigned STAT_CLR_BUSY = 2;
    localparam int unsigned STAT_ERR      = 3;

    localparam int unsigned CMD_CLEAR   = 0;
    localparam int unsigned CMD_ERR_CLR = 7;

    typedef logic [14:0] fb_addr_t;

    typedef struct packed {
        fb_addr_t   addr;
        logic [2:0] colour;
    } fb_wr_t;

    typedef enum logic [0:0] {
        ClrIdle,
        ClrFill
    } clr_state_t;

    // y*160 + x via shifts; operands are already range-checked by the caller
    function automatic fb_addr_t pix_addr(input logic [7:0] x, input logic [6:0] y);
        fb_addr_t yy;
        yy = fb_addr_t'(y);
        return (yy << 7) + (yy << 5) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU register bus, scanout port and framebuffer RAM port of the arbiter.
interface vga_fb_arbiter_if;
    import vga_pkg::*;

    logic       CE;
    logic       RW;
    logic [1:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       SCAN_REQ;
    fb_addr_t   SCAN_ADDR;
    logic [2:0] SCAN_DATA;
    logic       SCAN_VALID;
    fb_addr_t   RAM_ADDR;
    logic       RAM_WE;
    logic [2:0] RAM_WDATA;
    logic [2:0] RAM_RDATA;

    modport master (
        output CE, RW, ADDR, DATA_IN, SCAN_REQ, SCAN_ADDR, RAM_RDATA,
        input  DATA_OUT, SCAN_DATA, SCAN_VALID, RAM_ADDR, RAM_WE, RAM_WDATA
    );

    modport slave (
        input  CE, RW, ADDR, DATA_IN, SCAN_REQ, SCAN_ADDR, RAM_RDATA,
        output DATA_OUT, SCAN_DATA, SCAN_VALID, RAM_ADDR, RAM_WE, RAM_WDATA
    );

endinterface

// File: rtl/fb_write_fifo.sv
// Posted-write FIFO with a combinational head; push and pop may coincide even when full.
module fb_write_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   push,
    input  fb_wr_t wdata,
    input  logic   pop,
    output fb_wr_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fb_wr_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port owner: scanout first, then clear engine, then posted CPU writes.
// Clear engine is built only when FB_CLEAR_EN is defined.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_W       = vga_pkg::FB_W,
    parameter int unsigned FB_H       = vga_pkg::FB_H
) (
    input logic             CLK,
    input logic             RST,
    vga_fb_arbiter_if.slave bus
);

    localparam logic [7:0] X_MAX    = 8'(FB_W - 1);
    localparam logic [6:0] Y_MAX    = 7'(FB_H - 1);
    localparam fb_addr_t   CLR_LAST = fb_addr_t'(FB_W * FB_H - 1);

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic       err_q;
    logic [7:0] data_out_q;
    logic       scan_valid_q;
    fb_addr_t   ram_addr_q;
    logic [2:0] ram_wdata_q;

    logic       cpu_wr, cpu_rd, pix_wr, cmd_wr, in_range;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    fb_wr_t     fifo_in, fifo_head;
    logic       clr_busy;
    fb_addr_t   clr_addr;
    logic [2:0] clr_colour;
    fb_addr_t   ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [7:0] status;

    assign cpu_wr   = bus.CE && !bus.RW;
    assign cpu_rd   = bus.CE && bus.RW;
    assign pix_wr   = cpu_wr && (bus.ADDR == REG_PIXEL);
    assign cmd_wr   = cpu_wr && (bus.ADDR == REG_CMD);
    assign in_range = (x_q <= X_MAX) && (y_q <= Y_MAX);

    // A full FIFO still accepts a push in a cycle where its head drains
    assign fifo_push      = pix_wr && in_range && (!fifo_full || fifo_pop);
    assign fifo_in.addr   = pix_addr(x_q, y_q);
    assign fifo_in.colour = bus.DATA_IN[2:0];

    fb_write_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (fifo_push),
        .wdata(fifo_in),
        .pop  (fifo_pop),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

`ifdef FB_CLEAR_EN
    clr_state_t clr_state_q;
    fb_addr_t   clr_cnt_q;
    logic [2:0] clr_colour_q;

    assign clr_busy   = (clr_state_q == ClrFill);
    assign clr_addr   = clr_cnt_q;
    assign clr_colour = clr_colour_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_state_q  <= ClrIdle;
            clr_cnt_q    <= '0;
            clr_colour_q <= '0;
        end else begin
            unique case (clr_state_q)
                ClrIdle: begin
                    if (cmd_wr && bus.DATA_IN[CMD_CLEAR]) begin
                        clr_colour_q <= bus.DATA_IN[3:1];
                        clr_cnt_q    <= '0;
                        clr_state_q  <= ClrFill;
                    end
                end
                ClrFill: begin
                    // Scanout owns the slot this cycle, so the clear waits
                    if (!bus.SCAN_REQ) begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        if (clr_cnt_q == CLR_LAST) begin
                            clr_state_q <= ClrIdle;
                        end
                    end
                end
            endcase
        end
    end
`else
    assign clr_busy   = 1'b0;
    assign clr_addr   = '0;
    assign clr_colour = '0;
`endif

    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 1'b0;
        ram_wdata = ram_wdata_q;
        fifo_pop  = 1'b0;
        if (bus.SCAN_REQ) begin
            ram_addr = bus.SCAN_ADDR;
        end else if (clr_busy) begin
            ram_addr  = clr_addr;
            ram_we    = 1'b1;
            ram_wdata = clr_colour;
        end else if (!fifo_empty) begin
            ram_addr  = fifo_head.addr;
            ram_we    = 1'b1;
            ram_wdata = fifo_head.colour;
            fifo_pop  = 1'b1;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_FULL]     = fifo_full;
        status[STAT_CLR_BUSY] = clr_busy;
        status[STAT_ERR]      = err_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q          <= '0;
            y_q          <= '0;
            err_q        <= 1'b0;
            data_out_q   <= '0;
            scan_valid_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            scan_valid_q <= bus.SCAN_REQ;
            ram_addr_q   <= ram_addr;
            ram_wdata_q  <= ram_wdata;
            if (cpu_wr) begin
                unique case (bus.ADDR)
                    REG_X: x_q <= bus.DATA_IN;
                    REG_Y: y_q <= bus.DATA_IN[6:0];
                    REG_PIXEL: begin
                        if (fifo_push) begin
                            if (x_q == X_MAX) begin
                                x_q <= '0;
                                y_q <= (y_q == Y_MAX) ? 7'd0 : y_q + 7'd1;
                            end else begin
                                x_q <= x_q + 8'd1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    REG_CMD: begin
                        if (bus.DATA_IN[CMD_ERR_CLR]) begin
                            err_q <= 1'b0;
                        end
                    end
                endcase
            end
            if (cpu_rd) begin
                unique case (bus.ADDR)
                    REG_X:     data_out_q <= x_q;
                    REG_Y:     data_out_q <= {1'b0, y_q};
                    REG_PIXEL: data_out_q <= '0;
                    REG_CMD:   data_out_q <= status;
                endcase
            end
        end
    end

    assign bus.DATA_OUT   = data_out_q;
    assign bus.SCAN_VALID = scan_valid_q;
    assign bus.SCAN_DATA  = scan_valid_q ? bus.RAM_RDATA : 3'b000;
    assign bus.RAM_ADDR   = ram_addr;
    assign bus.RAM_WE     = ram_we;
    assign bus.RAM_WDATA  = ram_wdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: register-op table plus scanout, overflow and clear sequences.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    always #10 CLK = ~CLK;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(
        .FIFO_DEPTH(4),
        .FB_W      (160),
        .FB_H      (120)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    typedef struct {
        logic       rw;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } op_t;

    int   tests = 0;
    int   fails = 0;
    wr_t  wr_log[$];
    int   scan_err = 0;
    int   overlap_err = 0;
    int   valid_cnt = 0;
    int   cycle = 0;
    int   first_wr_cycle = -1;
    int   last_wr_cycle = -1;
    logic prev_req = 1'b0;
    fb_addr_t prev_saddr = '0;

    function automatic logic [2:0] rd_model(input fb_addr_t a);
        return a[2:0] ^ a[5:3];
    endfunction

    // Synchronous-read RAM stand-in with data derived from the address
    always @(posedge CLK) bus.RAM_RDATA <= rd_model(bus.RAM_ADDR);

    always @(negedge CLK) begin
        cycle++;
        if (!RST) begin
            if (bus.RAM_WE) begin
                wr_log.push_back('{addr: int'(bus.RAM_ADDR), data: int'(bus.RAM_WDATA)});
                if (first_wr_cycle < 0) first_wr_cycle = cycle;
                last_wr_cycle = cycle;
            end
            if (bus.RAM_WE && bus.SCAN_REQ) overlap_err++;
            if (bus.SCAN_VALID !== prev_req) scan_err++;
            if (prev_req && (bus.SCAN_DATA !== rd_model(prev_saddr))) scan_err++;
            if (bus.SCAN_VALID) valid_cnt++;
        end
        prev_req   = bus.SCAN_REQ;
        prev_saddr = bus.SCAN_ADDR;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        bus.CE = 1'b1; bus.RW = 1'b0; bus.ADDR = a; bus.DATA_IN = d;
        @(posedge CLK); #1;
        bus.CE = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge CLK); #1;
        bus.CE = 1'b1; bus.RW = 1'b1; bus.ADDR = a;
        @(posedge CLK); #1;
        bus.CE = 1'b0;
        d = bus.DATA_OUT;
    endtask

    task automatic check_log(input string name, input int idx, input int unsigned a,
                             input int unsigned d);
        if (idx >= wr_log.size()) begin
            check({name, "_present"}, 32'(wr_log.size()), 32'(idx + 1));
        end else begin
            check({name, "_addr"}, wr_log[idx].addr, a);
            check({name, "_data"}, wr_log[idx].data, d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t        ops[31];
        logic [7:0] rd;
        int         waited;
        int         bad;

        ops = '{
            '{1'b0, REG_X,     8'd159,  8'h00},
            '{1'b0, REG_Y,     8'd0,    8'h00},
            '{1'b0, REG_PIXEL, 8'h05,   8'h00},
            '{1'b1, REG_X,     8'h00,   8'd0},
            '{1'b1, REG_Y,     8'h00,   8'd1},
            '{1'b1, REG_PIXEL, 8'h00,   8'h00},
            '{1'b1, REG_CMD,   8'h00,   8'h01},
            '{1'b0, REG_X,     8'd10,   8'h00},
            '{1'b0, REG_Y,     8'h83,   8'h00},
            '{1'b1, REG_Y,     8'h00,   8'd3},
            '{1'b0, REG_PIXEL, 8'hFA,   8'h00},
            '{1'b1, REG_X,     8'h00,   8'd11},
            '{1'b0, REG_X,     8'd159,  8'h00},
            '{1'b0, REG_Y,     8'd119,  8'h00},
            '{1'b0, REG_PIXEL, 8'h07,   8'h00},
            '{1'b1, REG_X,     8'h00,   8'd0},
            '{1'b1, REG_Y,     8'h00,   8'd0},
            '{1'b0, REG_Y,     8'd120,  8'h00},
            '{1'b0, REG_PIXEL, 8'h01,   8'h00},
            '{1'b1, REG_CMD,   8'h00,   8'h09},
            '{1'b1, REG_Y,     8'h00,   8'd120},
            '{1'b1, REG_X,     8'h00,   8'd0},
            '{1'b0, REG_CMD,   8'h80,   8'h00},
            '{1'b1, REG_CMD,   8'h00,   8'h01},
            '{1'b0, REG_Y,     8'd0,    8'h00},
            '{1'b0, REG_X,     8'd160,  8'h00},
            '{1'b0, REG_PIXEL, 8'h03,   8'h00},
            '{1'b1, REG_X,     8'h00,   8'd160},
            '{1'b1, REG_CMD,   8'h00,   8'h09},
            '{1'b0, REG_CMD,   8'h80,   8'h00},
            '{1'b1, REG_CMD,   8'h00,   8'h01}
        };

        bus.CE = 1'b0; bus.RW = 1'b0; bus.ADDR = '0; bus.DATA_IN = '0;
        bus.SCAN_REQ = 1'b0; bus.SCAN_ADDR = '0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        check("reset_ram_we",     32'(bus.RAM_WE),     0);
        check("reset_ram_addr",   32'(bus.RAM_ADDR),   0);
        check("reset_ram_wdata",  32'(bus.RAM_WDATA),  0);
        check("reset_scan_valid", 32'(bus.SCAN_VALID), 0);
        check("reset_scan_data",  32'(bus.SCAN_DATA),  0);
        check("reset_data_out",   32'(bus.DATA_OUT),   0);

        // Register-op table
        for (int i = 0; i < 31; i++) begin
            if (ops[i].rw) begin
                cpu_read(ops[i].a, rd);
                check($sformatf("tbl%0d_reg%0d", i, ops[i].a), 32'(rd), 32'(ops[i].exp));
            end else begin
                cpu_write(ops[i].a, ops[i].d);
            end
        end
        repeat (3) @(posedge CLK);
        check("tbl_wr_count", 32'(wr_log.size()), 3);
        check_log("tbl_wr0", 0, 159, 5);
        check_log("tbl_wr1", 1, 490, 2);
        check_log("tbl_wr2", 2, 19199, 7);

        // Scanout holds the RAM for 10 cycles while three pixels are posted
        cpu_write(REG_X, 8'd0);
        cpu_write(REG_Y, 8'd2);
        repeat (2) @(posedge CLK);
        wr_log.delete();
        valid_cnt = 0;
        fork
            begin
                @(posedge CLK); #1;
                for (int i = 0; i < 10; i++) begin
                    bus.SCAN_REQ  = 1'b1;
                    bus.SCAN_ADDR = fb_addr_t'(100 + 7 * i);
                    @(posedge CLK); #1;
                end
                bus.SCAN_REQ = 1'b0;
            end
            begin
                cpu_write(REG_PIXEL, 8'd1);
                cpu_write(REG_PIXEL, 8'd2);
                cpu_write(REG_PIXEL, 8'd3);
            end
        join
        repeat (6) @(posedge CLK);
        check("scan_valid_count", 32'(valid_cnt), 10);
        check("scan_wr_count", 32'(wr_log.size()), 3);
        check_log("scan_wr0", 0, 320, 1);
        check_log("scan_wr1", 1, 321, 2);
        check_log("scan_wr2", 2, 322, 3);

        // Overflow while scanout starves the FIFO
        cpu_write(REG_X, 8'd0);
        cpu_write(REG_Y, 8'd3);
        repeat (2) @(posedge CLK);
        wr_log.delete();
        @(posedge CLK); #1;
        bus.SCAN_REQ = 1'b1; bus.SCAN_ADDR = 15'd77;
        for (int i = 1; i <= 5; i++) cpu_write(REG_PIXEL, 8'(i));
        cpu_read(REG_CMD, rd);
        check("ovf_status", 32'(rd), 32'h0A);
        cpu_read(REG_X, rd);
        check("ovf_x", 32'(rd), 4);
        cpu_write(REG_CMD, 8'h80);
        cpu_read(REG_CMD, rd);
        check("ovf_status_errclr", 32'(rd), 32'h02);
        check("ovf_no_write_during_scan", 32'(wr_log.size()), 0);
        bus.SCAN_REQ = 1'b0;
        repeat (8) @(posedge CLK);
        check("ovf_wr_count", 32'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) check_log($sformatf("ovf_wr%0d", i), i, 480 + i, i + 1);
        cpu_read(REG_CMD, rd);
        check("ovf_status_drained", 32'(rd), 32'h01);

`ifdef FB_CLEAR_EN
        // Full clear with a pixel posted mid-clear; the pixel must land last
        wr_log.delete();
        first_wr_cycle = -1;
        cpu_write(REG_CMD, 8'h05);
        cpu_write(REG_X, 8'd0);
        cpu_write(REG_Y, 8'd0);
        cpu_write(REG_PIXEL, 8'd7);
        cpu_read(REG_CMD, rd);
        check("clr_status_busy", 32'(rd), 32'h04);
        cpu_write(REG_CMD, 8'h03);
        waited = 0;
        while (wr_log.size() < 19201 && waited < 20000) begin
            @(posedge CLK);
            waited++;
        end
        repeat (3) @(posedge CLK);
        check("clr_wr_count", 32'(wr_log.size()), 19201);
        bad = 0;
        for (int i = 0; i < 19200 && i < wr_log.size(); i++) begin
            if (wr_log[i].addr != i || wr_log[i].data != 2) bad++;
        end
        check("clr_fill_pattern", 32'(bad), 0);
        check_log("clr_pixel_last", 19200, 0, 7);
        check("clr_duration", 32'(last_wr_cycle - first_wr_cycle), 19200);
        cpu_read(REG_CMD, rd);
        check("clr_status_done", 32'(rd), 32'h01);
`else
        // Without the clear engine CMD bit0 does nothing
        wr_log.delete();
        cpu_write(REG_CMD, 8'h05);
        cpu_read(REG_CMD, rd);
        check("noclr_status", 32'(rd), 32'h01);
        repeat (4) @(posedge CLK);
        check("noclr_no_writes", 32'(wr_log.size()), 0);
`endif

        check("scan_timing_errors", 32'(scan_err), 0);
        check("scan_write_overlap", 32'(overlap_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
